uart_tx: RTL and testbench

Byte-wide UART transmitter serving the command parser's transmit side. It accepts a byte on `tx_data` when strobed by `new_tx_data` and reports `tx_busy` while a frame is in flight. It serializes the byte LSB-first as an 8N1 frame (8E1/8O1 when the parity build option is set) on `tx`, which drives the board UART TX pin. It runs on the 100 MHz board clock.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_tx.sv | 155 +++++++++++++++
 tb/tb_uart_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default baud divisor, data width.
package uart_pkg;

    localparam int UART_CLKS_115200_100MHZ = 868;
    localparam int UART_DATA_W             = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Even parity of the byte, inverted when odd parity is selected.
    function automatic logic parity_bit(input logic [UART_DATA_W-1:0] data,
                                        input logic                   odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: o_bit_tick marks the last clock of each bit period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_115200_100MHZ
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clear,
    output logic o_bit_tick
);

    localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_bit_tick = (r_count == LP_LAST);

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter, LSB-first 8N1 frame; defining UART_TX_PARITY_EN
// adds a parity bit (even, or odd when PARITY_ODD=1) for an 11-bit frame.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_115200_100MHZ,
    parameter int PARITY_ODD   = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   new_tx_data,
    output logic                   tx_busy,
    output logic                   tx,
    output logic                   tx_done
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
        $error("uart_tx: CLKS_PER_BIT must be 2..65535 and PARITY_ODD 0 or 1");
    end

    uart_state_t            r_state;
    uart_state_t            w_state_nxt;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] w_shift_nxt;
    logic [2:0]             r_bit_idx;
    logic [2:0]             w_bit_idx_nxt;
    logic                   r_tx;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_tx_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;
    logic                   w_tick;
    logic                   w_clear;
`ifdef UART_TX_PARITY_EN
    logic                   r_parity;
    logic                   w_parity_nxt;
`endif

    // Held clear while idle so the start bit gets a full period; every other
    // state change happens on a tick, which restarts the count as well.
    assign w_clear = (r_state == ST_IDLE) || w_tick;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rstn      (rstn),
        .i_clear   (w_clear),
        .o_bit_tick(w_tick)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_done_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt  = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                if (new_tx_data) begin
                    w_state_nxt   = ST_START;
                    w_shift_nxt   = tx_data;
                    w_bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt  = parity_bit(tx_data, 1'(PARITY_ODD));
`endif
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_idx_nxt = '0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt   = ST_PARITY;
`else
                        w_state_nxt   = ST_STOP;
`endif
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so tx/tx_busy stay registered.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_nxt = w_parity_nxt;
`endif
            default:   w_tx_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
`ifdef UART_TX_PARITY_EN
        r_parity <= w_parity_nxt;
`endif
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx with a frame-position reference model.
module tb_uart_tx;

    localparam int C  = 4;
    localparam int PO = 0;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int F     = NB * C;
    localparam int LOG_N = 8192;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       new_tx_data = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy;
    logic       tx;
    logic       tx_done;

    uart_tx #(
        .CLKS_PER_BIT(C),
        .PARITY_ODD  (PO)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .tx_data    (tx_data),
        .new_tx_data(new_tx_data),
        .tx_busy    (tx_busy),
        .tx         (tx),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic chk_en  = 1'b0;
    logic tx_log   [LOG_N];
    logic busy_log [LOG_N];
    logic done_log [LOG_N];

    always @(posedge clk) cyc <= cyc + 1;

    // Expected line levels of a whole frame, index = bit slot on the wire.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        if (NB == 11) f[9] = (^b) ^ 1'(PO);
        return f;
    endfunction

    // Reference: position inside the current frame (-1 = idle).
    int          m_pos   = -1;
    logic [10:0] m_frame = '1;
    logic        m_done  = 1'b0;

    always @(posedge clk) begin
        if (!rstn) begin
            m_pos  = -1;
            m_done = 1'b0;
        end else if (m_pos < 0) begin
            m_done = 1'b0;
            if (new_tx_data) begin
                m_pos   = 0;
                m_frame = frame_of(tx_data);
            end
        end else begin
            m_pos  = m_pos + 1;
            m_done = 1'b0;
            if (m_pos == F) begin
                m_pos  = -1;
                m_done = 1'b1;
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step();
        logic et, eb;
        @(negedge clk);
        tx_log[cyc % LOG_N]   = tx;
        busy_log[cyc % LOG_N] = tx_busy;
        done_log[cyc % LOG_N] = tx_done;
        if (chk_en) begin
            eb = (m_pos >= 0);
            et = (m_pos < 0) ? 1'b1 : m_frame[m_pos / C];
            n_tests++;
            if ({tx, tx_busy, tx_done} !== {et, eb, m_done}) begin
                n_fail++;
                $display("FAIL model_cycle: cyc=%0d tx/busy/done got %b%b%b expected %b%b%b",
                         cyc, tx, tx_busy, tx_done, et, eb, m_done);
            end
        end
    endtask

    task automatic send(input logic [7:0] b, output int a);
        tx_data     = b;
        new_tx_data = 1'b1;
        step();
        a           = cyc;
        new_tx_data = 1'b0;
        tx_data     = 8'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (tx_busy !== 1'b0 && k < 4 * F) begin
            step();
            tx_data = 8'($urandom);
            k++;
        end
        if (k >= 4 * F) check({name, "_timeout"}, 1, 0);
    endtask

    task automatic check_frame(input string name, input int a, input logic [7:0] b);
        logic [10:0] fr;
        int nb = 0;
        fr = frame_of(b);
        for (int j = 0; j < NB; j++)
            check({name, "_bit"}, int'(tx_log[(a + j*C + C/2) % LOG_N]), int'(fr[j]));
        for (int k = a; k < a + F; k++) nb += int'(busy_log[k % LOG_N]);
        check({name, "_busy_len"}, nb, F);
        check({name, "_done"}, int'(done_log[(a + F) % LOG_N]), 1);
    endtask

    initial begin
        int a, a2, cnt, off;
        logic [9:0]  exp_a5;
        logic [7:0]  b;
        exp_a5 = 10'b11_0100_1010;

        // Reset idle
        step();
        chk_en = 1'b1;
        repeat (4) step();
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_done", int'(tx_done), 0);
        rstn = 1'b1;
        cnt = 0;
        repeat (100) begin
            step();
            cnt += int'(tx === 1'b1);
        end
        check("idle_high_cycles", cnt, 100);

        // Single byte 0xA5
        send(8'hA5, a);
        wait_idle("a5");
        step();
        for (int j = 0; j < 9; j++)
            check("a5_bit", int'(tx_log[(a + j*C + C/2) % LOG_N]), int'(exp_a5[j]));
        check("a5_stop", int'(tx_log[(a + (NB-1)*C + C/2) % LOG_N]), 1);
        cnt = 0;
        for (int k = a - 1; k <= a + F + 1; k++) cnt += int'(busy_log[k % LOG_N]);
        check("a5_busy_cycles", cnt, F);
        cnt = 0;
        for (int k = a - 1; k <= a + F + 1; k++) cnt += int'(done_log[k % LOG_N]);
        check("a5_done_count", cnt, 1);
        check("a5_done_at_F", int'(done_log[(a + F) % LOG_N]), 1);
        check_frame("a5", a, 8'hA5);

        // Back-to-back 0x00 then 0xFF on the first idle cycle
        send(8'h00, a);
        wait_idle("b2b_first");
        send(8'hFF, a2);
        check("b2b_gap", a2 - a, F + 1);
        check("b2b_idle_tx", int'(tx_log[(a + F) % LOG_N]), 1);
        wait_idle("b2b_second");
        check_frame("b2b_00", a, 8'h00);
        check_frame("b2b_ff", a2, 8'hFF);
        repeat (3) step();

        // Strobe while busy is dropped
        send(8'h3C, a);
        repeat (9) step();
        tx_data     = 8'hC3;
        new_tx_data = 1'b1;
        step();
        new_tx_data = 1'b0;
        wait_idle("drop");
        repeat (3) step();
        check_frame("drop_3c", a, 8'h3C);
        cnt = 0;
        for (int k = a; k <= a + F + 2; k++) cnt += int'(done_log[k % LOG_N]);
        check("drop_done_count", cnt, 1);
        check("drop_no_restart", int'(busy_log[(a + F + 2) % LOG_N]), 0);

        // Reset mid-frame, then a clean frame
        send(8'h81, a);
        repeat (16) step();
        rstn = 1'b0;
        step();
        check("midrst_tx", int'(tx), 1);
        check("midrst_busy", int'(tx_busy), 0);
        check("midrst_done", int'(tx_done), 0);
        rstn = 1'b1;
        cnt = 0;
        repeat (F) begin
            step();
            cnt += int'(tx_done === 1'b1) + int'(tx_busy === 1'b1);
        end
        check("midrst_quiet", cnt, 0);
        send(8'h55, a);
        wait_idle("post_rst");
        check_frame("post_rst_55", a, 8'h55);
        step();

`ifdef UART_TX_PARITY_EN
        send(8'h07, a);
        wait_idle("par");
        check("par_bit_even", int'(tx_log[(a + 9*C + C/2) % LOG_N]), 1);
        check("par_frame_len", int'(done_log[(a + 44) % LOG_N]), 1);
        check("par_busy_last", int'(busy_log[(a + 43) % LOG_N]), 1);
        step();
`endif

        // Randomized frames with stray strobes, including on the done edge
        for (int it = 0; it < 40; it++) begin
            b = 8'($urandom);
            send(b, a);
            off = ($urandom_range(0, 2) == 0) ? F : int'($urandom_range(1, F + 4));
            for (int k = 1; k <= F; k++) begin
                if (k == off) begin
                    new_tx_data = 1'b1;
                    tx_data     = 8'($urandom);
                end
                step();
                new_tx_data = 1'b0;
                tx_data     = 8'($urandom);
            end
            check_frame("rand", a, b);
            repeat ($urandom_range(0, 3)) step();
        end
        repeat (2 * F) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
